// File: rtl/spi_slave_rx_if.sv
// rtl/spi_slave_rx_if.sv - SPI pins and register-side bus of spi_slave_rx
// Signals:
//   spi_sclk, spi_cs_n, spi_mosi : SPI master -> slave (asynchronous to clk)
//   spi_miso, spi_miso_oe        : slave -> SPI master, with tristate enable
//   wr_valid, wr_addr, wr_data   : one-clk register write strobe with address/data
//   rd_addr, rd_data             : register read address out, read data back in
//   frame_done, byte_cnt         : end-of-frame pulse and data byte count
interface spi_slave_rx_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_done;
  logic [2:0] byte_cnt;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, rd_data,
    output spi_miso, spi_miso_oe, wr_valid, wr_addr, wr_data, rd_addr,
           frame_done, byte_cnt
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, rd_data,
    input  spi_miso, spi_miso_oe, wr_valid, wr_addr, wr_data, rd_addr,
           frame_done, byte_cnt
  );
endinterface

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 slave that decodes register read/write frames
// Ports:
//   clk   : system clock, at least 4x spi_sclk
//   rst_n : asynchronous active-low reset
//   bus   : spi_slave_rx_if.slave -- SPI pins in/out, register write strobe,
//           read address/data, frame_done pulse with byte_cnt
// Frame: address byte (bit7 = 1 read / 0 write, bits[6:0] start address),
// then any number of data bytes at auto-incrementing addresses.
module spi_slave_rx (
  input  logic          clk,
  input  logic          rst_n,
  spi_slave_rx_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e     state_q, state_d;

  // [0],[1] form the synchronizer; [2] is the history bit for edge detection
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  // After reset the synchronizers hold their reset values for two clocks, so a
  // cs_n that is already low would look like a falling edge. warm_q waits for
  // the chain to carry real pin values; armed_q then waits for cs_n high.
  logic [1:0] warm_q;
  logic       armed_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic       rw_q, rw_d;
  logic [6:0] ptr_q, ptr_d;
  logic [7:0] tx_q, tx_d;
  logic       load_pend_q, load_pend_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       frame_done_q, frame_done_d;
  logic [2:0] byte_cnt_q, byte_cnt_d;

  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0] rx_byte;
  logic       miso_oe;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = armed_q & cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign rx_byte   = {rx_q[6:0], mosi_sync_q[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= 3'b000;
      cs_sync_q    <= 3'b111;
      mosi_sync_q  <= 2'b00;
      warm_q       <= 2'b00;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      rx_q         <= 8'h00;
      rw_q         <= 1'b0;
      ptr_q        <= 7'h00;
      tx_q         <= 8'h00;
      load_pend_q  <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= 7'h00;
      wr_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      byte_cnt_q   <= 3'd0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[1:0], bus.spi_sclk};
      cs_sync_q    <= {cs_sync_q[1:0], bus.spi_cs_n};
      mosi_sync_q  <= {mosi_sync_q[0], bus.spi_mosi};
      warm_q       <= {warm_q[0], 1'b1};
      armed_q      <= armed_q | (warm_q[1] & cs_sync_q[1]);
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      rw_q         <= rw_d;
      ptr_q        <= ptr_d;
      tx_q         <= tx_d;
      load_pend_q  <= load_pend_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    rw_d         = rw_q;
    ptr_d        = ptr_q;
    tx_d         = tx_q;
    load_pend_d  = load_pend_q;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    byte_cnt_d   = byte_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_ADDR;
          bit_cnt_d   = 3'd0;
          rx_d        = 8'h00;
          rw_d        = 1'b0;
          tx_d        = 8'h00;
          load_pend_d = 1'b0;
          byte_cnt_d  = 3'd0;
        end
      end

      ST_ADDR: begin
        // cs_n rise wins over a byte completing in the same cycle
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d     = ST_DATA;
            rw_d        = rx_byte[7];
            ptr_d       = rx_byte[6:0];
            load_pend_d = rx_byte[7];
          end
        end
      end

      ST_DATA: begin
        if (cs_rise) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rw_q) begin
                load_pend_d = 1'b1;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
              end
              ptr_d = ptr_q + 7'd1;
              if (byte_cnt_q != 3'd7) begin
                byte_cnt_d = byte_cnt_q + 3'd1;
              end
            end
          end
          // rd_data has had at least one clk to follow ptr_q by the time the
          // first falling edge after a byte boundary is detected.
          if (sclk_fall && rw_q) begin
            if (load_pend_q) begin
              tx_d        = bus.rd_data;
              load_pend_d = 1'b0;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign miso_oe         = (state_q == ST_DATA) & rw_q;
  assign bus.spi_miso_oe = miso_oe;
  assign bus.spi_miso    = miso_oe & tx_q[7];
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.rd_addr     = ptr_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.byte_cnt    = byte_cnt_q;

endmodule
